// File: rtl/axis_write_engine.sv
// axis_write_engine: one descriptor in, AXI AW bursts and packed W beats out.
// Stream words are packed R per AXI beat, queued in a first-word-fall-through
// FIFO, and drained on W with wlast following the same burst partition as AW.
module axis_write_engine #(
  parameter int unsigned BUF_AWIDTH     = 9,
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned BURST_BEATS    = 16,
  parameter int unsigned AXI_LEN_WIDTH  = 8,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic                      axi_awvalid,
  output logic                      axi_wlast,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      valid,
  output logic                      ready
);

  localparam int unsigned R      = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned BYTES  = AXI_DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << BUF_AWIDTH;
  localparam int unsigned LANE_W = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned POS_W  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int unsigned CNT_W  = BUF_AWIDTH + 1;

  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_BEATS * BYTES);
  localparam logic [CFG_DWIDTH-1:0]     BB_C        = CFG_DWIDTH'(BURST_BEATS);
  localparam logic [LANE_W-1:0]         LANE_LAST   = LANE_W'(R - 1);
  localparam logic [POS_W-1:0]          POS_LAST    = POS_W'(BURST_BEATS - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [CFG_DWIDTH:0]       len_round;
  logic [CFG_DWIDTH-1:0]     cfg_beats, first_beats, next_beats;
  logic [CFG_DWIDTH-1:0]     aw_rem, w_rem, words_rem;
  logic [AXI_ADDR_WIDTH-1:0] start_addr;
  logic [POS_W-1:0]          w_pos;
  logic [LANE_W-1:0]         lane;
  logic [AXI_DATA_WIDTH-1:0] acc, acc_nxt, push_data;
  logic                      push_en;
  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_AWIDTH-1:0]     wptr, rptr;
  logic [CNT_W-1:0]          count;
  logic start, aw_hs, w_hs, s_hs, group_done, aw_fin, w_fin;

  assign cfg_ready  = (state == ST_IDLE);
  assign start      = cfg_valid && cfg_ready && (cfg_length != '0);
  assign aw_hs      = axi_awvalid && axi_awready;
  assign w_hs       = axi_wvalid && axi_wready;
  assign s_hs       = valid && ready;
  assign group_done = (lane == LANE_LAST) || (words_rem == CFG_DWIDTH'(1));
  assign start_addr = AXI_ADDR_WIDTH'(cfg_address) & ~(BURST_BYTES - AXI_ADDR_WIDTH'(1));

  // Ready uses the registered count plus the pending packer write, so a
  // completing word is only taken when its FIFO slot is guaranteed.
  assign ready      = (state == ST_RUN) && (words_rem != '0) &&
                      ((count + CNT_W'(push_en)) < CNT_W'(DEPTH));
  assign axi_wvalid = (count != '0);
  assign axi_wdata  = axi_wvalid ? mem[rptr] : '0;
  assign axi_wlast  = axi_wvalid && ((w_pos == POS_LAST) || (w_rem == CFG_DWIDTH'(1)));

  // Descriptor decode: beat count and burst sizing.
  always_comb begin
    len_round   = {1'b0, cfg_length} + (CFG_DWIDTH + 1)'(R - 1);
    cfg_beats   = CFG_DWIDTH'(len_round / (CFG_DWIDTH + 1)'(R));
    first_beats = (cfg_beats > BB_C) ? BB_C : cfg_beats;
    next_beats  = (aw_rem > BB_C) ? BB_C : aw_rem;
  end

  // Completion terms include handshakes happening this cycle so cfg_ready
  // rises right after the final one.
  always_comb begin
    aw_fin = !axi_awvalid || (axi_awready && (aw_rem == '0));
    w_fin  = (w_rem == '0) || ((w_rem == CFG_DWIDTH'(1)) && w_hs);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: zero-length descriptors never leave idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (aw_fin && w_fin) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // AW channel: load first burst on acceptance, step to the next on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axi_awvalid <= 1'b0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      aw_rem      <= '0;
    end else if (start) begin
      axi_awvalid <= 1'b1;
      axi_awaddr  <= start_addr;
      axi_awlen   <= AXI_LEN_WIDTH'(first_beats - CFG_DWIDTH'(1));
      aw_rem      <= cfg_beats - first_beats;
    end else if (aw_hs) begin
      if (aw_rem != '0) begin
        axi_awaddr <= axi_awaddr + BURST_BYTES;
        axi_awlen  <= AXI_LEN_WIDTH'(next_beats - CFG_DWIDTH'(1));
        aw_rem     <= aw_rem - next_beats;
      end else begin
        axi_awvalid <= 1'b0;
      end
    end
  end

  // Lane insertion of the incoming word into the packing accumulator.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[lane*DATA_WIDTH +: DATA_WIDTH] = data;
  end

  // Stream intake and packer; a finished group is handed to the FIFO next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_rem <= '0;
      lane      <= '0;
      acc       <= '0;
      push_data <= '0;
      push_en   <= 1'b0;
    end else begin
      push_en <= s_hs && group_done;
      if (start) begin
        words_rem <= cfg_length;
        lane      <= '0;
        acc       <= '0;
      end else if (s_hs) begin
        words_rem <= words_rem - CFG_DWIDTH'(1);
        if (group_done) begin
          push_data <= acc_nxt;
          acc       <= '0;
          lane      <= '0;
        end else begin
          acc  <= acc_nxt;
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) wptr <= wptr + BUF_AWIDTH'(1);
      if (w_hs)    rptr <= rptr + BUF_AWIDTH'(1);
      count <= count + CNT_W'(push_en) - CNT_W'(w_hs);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr] <= push_data;
  end

  // W beat accounting for wlast and completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_rem <= '0;
      w_pos <= '0;
    end else if (start) begin
      w_rem <= cfg_beats;
      w_pos <= '0;
    end else if (w_hs) begin
      w_rem <= w_rem - CFG_DWIDTH'(1);
      w_pos <= (w_pos == POS_LAST) ? '0 : w_pos + POS_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_write_engine.sv
// Bench for axis_write_engine: 64-bit AXI, 32-bit stream (two words per beat),
// 16-beat bursts, 16-entry FIFO. Expected AW/W traffic is derived from the
// descriptor and the stream words the bench sends.
module tb_axis_write_engine;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cfg_address = '0, cfg_length = '0;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic          axi_awready = 1'b0, axi_awvalid, axi_wlast, axi_wvalid, axi_wready = 1'b0;
  logic [31:0]   axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [AW-1:0] axi_wdata;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0, ready;

  axis_write_engine #(
    .BUF_AWIDTH(4), .CFG_DWIDTH(32), .BURST_BEATS(16), .AXI_LEN_WIDTH(8),
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_address(cfg_address), .cfg_length(cfg_length),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_wlast(axi_wlast), .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .data(data), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [AW-1:0] data; logic last; } w_t;

  aw_t exp_aw[$], aw_log[$];
  w_t  exp_w[$],  w_log[$];
  logic [DW-1:0] src_words [256];
  int  src_len = 0, sent = 0;
  int  vprob = 100, aw_prob = 100, w_prob = 100;
  bit  w_toggle = 1'b0, stream_hs = 1'b0, model_idle = 1'b1;
  int  vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected traffic from the descriptor: beats = ceil(len/2), bursts of up to 16.
  task automatic load_model(input logic [31:0] addr, input int len);
    int n, rem, b;
    logic [31:0] a;
    aw_t t;
    w_t  w;
    n   = (len + 1) / 2;
    rem = n;
    a   = addr & ~32'h7F;
    while (rem > 0) begin
      b = (rem > 16) ? 16 : rem;
      t.addr = a;
      t.len  = 8'(b - 1);
      exp_aw.push_back(t);
      a   = a + 32'(b * 8);
      rem = rem - b;
    end
    for (int i = 0; i < n; i++) begin
      w.data[31:0]  = src_words[2*i];
      w.data[63:32] = (2*i + 1 < len) ? src_words[2*i+1] : 32'h0;
      w.last        = ((i % 16) == 15) || (i == n - 1);
      exp_w.push_back(w);
    end
    model_idle = (len == 0);
  endtask

  // Slave ready generation.
  initial begin
    forever begin
      @(posedge clk); #1;
      axi_awready = ($urandom_range(99) < aw_prob);
      axi_wready  = w_toggle ? ~axi_wready : ($urandom_range(99) < w_prob);
    end
  end

  // Stream source; words past the transfer length carry junk that must never be taken.
  initial begin
    forever begin
      @(negedge clk);
      stream_hs = valid && ready && rst;
      @(posedge clk); #1;
      if (stream_hs) sent++;
      valid = ($urandom_range(99) < vprob);
      data  = (sent < src_len) ? src_words[sent] : (32'hDEAD_0000 | 32'(sent));
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    aw_t a;
    w_t  w;
    forever begin
      @(negedge clk);
      if (!rst) continue;
      check("cfg_ready", cfg_ready, model_idle);
      check("awvalid", axi_awvalid, exp_aw.size() != 0);
      if (axi_awvalid && exp_aw.size() != 0) begin
        check("awaddr", axi_awaddr, exp_aw[0].addr);
        check("awlen", axi_awlen, exp_aw[0].len);
        if (axi_awready) begin
          a.addr = axi_awaddr; a.len = axi_awlen;
          aw_log.push_back(a);
          void'(exp_aw.pop_front());
        end
      end
      if (axi_wvalid) begin
        if (exp_w.size() == 0) check("w_extra_beat", 1, 0);
        else begin
          check("wdata", axi_wdata, exp_w[0].data);
          check("wlast", axi_wlast, exp_w[0].last);
          if (axi_wready) begin
            w.data = axi_wdata; w.last = axi_wlast;
            w_log.push_back(w);
            void'(exp_w.pop_front());
          end
        end
      end
      if (ready) check("ready_allowed", !model_idle && (sent < src_len), 1);
      if (cfg_valid && model_idle) load_model(cfg_address, int'(cfg_length));
      else if (!model_idle && exp_aw.size() == 0 && exp_w.size() == 0) model_idle = 1'b1;
    end
  end

  task automatic start_xfer(input logic [31:0] addr, input int len);
    sent = 0; src_len = len;
    aw_log.delete(); w_log.delete();
    @(posedge clk); #2;
    cfg_address = addr; cfg_length = 32'(len); cfg_valid = 1'b1;
    @(posedge clk); #2;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (model_idle) break;
    end
    check("done_in_budget", model_idle, 1);
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", axi_awvalid, 0);
    check("rst_wvalid", axi_wvalid, 0);
    check("rst_wlast", axi_wlast, 0);
    check("rst_ready", ready, 0);
    check("rst_awaddr", axi_awaddr, 0);
    check("rst_awlen", axi_awlen, 0);
    check("rst_wdata", axi_wdata, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    @(posedge clk); #2 rst = 1'b1;

    // Sequential words 1..40 at 0x1000.
    for (int i = 0; i < 40; i++) src_words[i] = 32'(i + 1);
    start_xfer(32'h1000, 40);
    wait_done(400);
    check("t1_aw_count", aw_log.size(), 2);
    check("t1_aw0_addr", aw_log[0].addr, 32'h1000);
    check("t1_aw0_len", aw_log[0].len, 15);
    check("t1_aw1_addr", aw_log[1].addr, 32'h1080);
    check("t1_aw1_len", aw_log[1].len, 3);
    check("t1_w_count", w_log.size(), 20);
    check("t1_w0", w_log[0].data, 64'h00000002_00000001);
    check("t1_w19", w_log[19].data, 64'h00000028_00000027);
    check("t1_last14", w_log[14].last, 0);
    check("t1_last15", w_log[15].last, 1);
    check("t1_last19", w_log[19].last, 1);

    // Odd length: partial final beat, minimum W latency.
    for (int i = 0; i < 5; i++) src_words[i] = 32'hA000_0000 + 32'(i);
    start_xfer(32'h1000, 5);
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      if (axi_wvalid && first == 0) first = k;
    end
    check("t2_w_latency", first, 4);
    wait_done(200);
    check("t2_aw_count", aw_log.size(), 1);
    check("t2_aw0_len", aw_log[0].len, 2);
    check("t2_w0", w_log[0].data, 64'hA0000001_A0000000);
    check("t2_w1", w_log[1].data, 64'hA0000003_A0000002);
    check("t2_w2", w_log[2].data, 64'h00000000_A0000004);
    check("t2_last2", w_log[2].last, 1);

    // AW stalled 5 cycles, wready toggling.
    for (int i = 0; i < 64; i++) src_words[i] = $urandom;
    aw_prob = 0; w_toggle = 1'b1;
    start_xfer(32'h0000_0400, 64);
    repeat (5) @(posedge clk);
    aw_prob = 100;
    wait_done(600);
    w_toggle = 1'b0;
    check("t3_aw_count", aw_log.size(), 2);
    check("t3_w_count", w_log.size(), 32);

    // FIFO fill with wready held low.
    for (int i = 0; i < 40; i++) src_words[i] = $urandom;
    w_prob = 0;
    start_xfer(32'h0000_8000, 40);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("t4_words_taken_full", sent, 32);
    check("t4_ready_full", ready, 0);
    w_prob = 100;
    wait_done(400);
    check("t4_w_count", w_log.size(), 20);

    // Zero length, then a descriptor pulsed mid-transfer.
    start_xfer(32'h4000, 0);
    @(negedge clk);
    check("t5_zero_cfg_ready", cfg_ready, 1);
    repeat (5) @(negedge clk);
    check("t5_zero_awvalid", axi_awvalid, 0);
    check("t5_zero_wvalid", axi_wvalid, 0);
    for (int i = 0; i < 40; i++) src_words[i] = $urandom;
    w_prob = 50;
    start_xfer(32'h3000, 40);
    repeat (6) @(posedge clk);
    #2 cfg_address = 32'h5000; cfg_length = 32'd7; cfg_valid = 1'b1;
    @(posedge clk); #2 cfg_valid = 1'b0;
    wait_done(600);
    w_prob = 100;
    check("t5_aw_count", aw_log.size(), 2);
    check("t5_aw1_addr", aw_log[1].addr, 32'h3080);

    // Reset during the second burst, then a clean transfer.
    for (int i = 0; i < 64; i++) src_words[i] = $urandom;
    start_xfer(32'h1000, 64);
    for (int c = 0; c < 500 && w_log.size() < 18; c++) @(negedge clk);
    check("t6_reached_burst2", w_log.size() >= 18, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    exp_aw.delete(); exp_w.delete(); model_idle = 1'b1; src_len = 0; sent = 0;
    #1;
    check("t6_awvalid", axi_awvalid, 0);
    check("t6_wvalid", axi_wvalid, 0);
    check("t6_wlast", axi_wlast, 0);
    check("t6_ready", ready, 0);
    check("t6_cfg_ready", cfg_ready, 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 32; i++) src_words[i] = 32'hC000_0000 + 32'(i);
    start_xfer(32'h2000, 32);
    wait_done(300);
    check("t6_aw_count", aw_log.size(), 1);
    check("t6_aw0_addr", aw_log[0].addr, 32'h2000);
    check("t6_aw0_len", aw_log[0].len, 15);
    check("t6_w_count", w_log.size(), 16);
    check("t6_w0", w_log[0].data, 64'hC0000001_C0000000);

    // Randomised descriptors and handshake pressure.
    for (int t = 0; t < 10; t++) begin
      int len;
      len = $urandom_range(120, 1);
      for (int i = 0; i < len; i++) src_words[i] = $urandom;
      vprob = $urandom_range(100, 30);
      aw_prob = $urandom_range(100, 30);
      w_prob = $urandom_range(100, 30);
      start_xfer($urandom, len);
      wait_done(3000);
      check("rand_w_count", w_log.size(), (len + 1) / 2);
      check("rand_aw_count", aw_log.size(), ((len + 1) / 2 + 15) / 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_write_engine.md
Name: axis_write_engine

Overview:
- Write-side AXI master engine: takes one transfer descriptor (start byte address, length in stream words) and drives the AXI write address (AW) and write data (W) channels.
- Buffers and packs an incoming valid/ready stream into AXI-width beats.
- Sits below the register-configured stream writer and beside the memory interconnect; combines the address generator and the write-data path behind one descriptor handshake.

Parameters:
- BUF_AWIDTH, 9, log2 depth of the AXI-word data FIFO.
- CFG_DWIDTH, 32, width of cfg_address and cfg_length.
- BURST_BEATS, 16, maximum beats per burst; power of two, at most 2^AXI_LEN_WIDTH.
- AXI_LEN_WIDTH, 8, width of axi_awlen.
- AXI_ADDR_WIDTH, 32, width of axi_awaddr.
- AXI_DATA_WIDTH, 32, AXI data width; integer multiple of DATA_WIDTH.
- DATA_WIDTH, 32, stream word width.
- Derived: R = AXI_DATA_WIDTH/DATA_WIDTH; BYTES = AXI_DATA_WIDTH/8.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_address  in  CFG_DWIDTH  start byte address.
- cfg_length  in  CFG_DWIDTH  transfer length in stream words.
- cfg_valid  in  1  descriptor valid.
- cfg_ready  out  1  engine idle; descriptor accepted on cfg_valid&cfg_ready.
- axi_awready  in  1  AW ready.
- axi_awaddr  out  AXI_ADDR_WIDTH  burst address.
- axi_awlen  out  AXI_LEN_WIDTH  burst beats minus 1.
- axi_awvalid  out  1  AW valid.
- axi_wlast  out  1  last beat of the burst.
- axi_wdata  out  AXI_DATA_WIDTH  write beat.
- axi_wvalid  out  1  W valid.
- axi_wready  in  1  W ready.
- data  in  DATA_WIDTH  stream word.
- valid  in  1  stream valid.
- ready  out  1  stream ready.

Behaviour:
- Reset (rst=0, any time, asynchronous): awvalid, wvalid, wlast, ready = 0; awaddr, awlen, wdata = 0; cfg_ready = 1. FIFO, packer and counters are cleared. A transfer in progress is abandoned.
- Descriptor acceptance:
  - Captured on cfg_valid&cfg_ready; cfg_ready drops the next cycle.
  - cfg_valid while busy is ignored.
  - Address low bits below log2(BURST_BEATS*BYTES) are forced to zero, so no burst crosses a 4 KB boundary.
- Beat count N = ceil(cfg_length/R).
  - Bursts are issued in order: floor(N/BURST_BEATS) full bursts, then one remainder burst if N mod BURST_BEATS ≠ 0.
  - cfg_length = 0: no AW or W activity; cfg_ready stays/returns high the next cycle.
- AW channel:
  - awvalid rises the cycle after acceptance.
  - awaddr/awlen are held stable until awvalid&awready.
  - Next burst is presented in the following cycle (awvalid may stay high continuously).
  - Address advances by beats*BYTES per burst; awlen = beats-1.
- Stream input:
  - ready = busy & words_remaining>0 & FIFO not full.
  - A word is accepted on valid&ready.
  - Words beyond cfg_length, or arriving while idle, are not accepted.
- Packing:
  - The first word of each group of R occupies bits [DATA_WIDTH-1:0] (little-endian lanes).
  - The packed word is written to the FIFO the cycle after its R-th word, or the cycle after the final transfer word.
  - A partial final word has its unused upper lanes zero.
- W channel:
  - FIFO is first-word-fall-through; wvalid asserts 2 cycles after the completing stream word (minimum latency).
  - wdata is held stable while wvalid&!wready.
  - A beat is consumed on wvalid&wready.
  - wlast is asserted on the final beat of each burst, using the same partition as AW.
  - W beats may lead their AW handshake.
- Completion:
  - Done when all AW handshakes and all N W handshakes have occurred.
  - cfg_ready rises the next cycle.
  - The FIFO is empty at completion.
- Full/empty:
  - FIFO full deasserts ready in the same cycle it becomes full, with no overflow.
  - FIFO empty deasserts wvalid, with no underflow.
  - Simultaneous FIFO write and read while full is permitted only via the read freeing space in the next cycle; ready is computed from the registered count.

Test Plan:
- R=1, BURST_BEATS=16, addr 0x1000, length 40, words 1..40, ready slaves → AW (0x1000,15), (0x1040,15), (0x1080,7); 40 W beats equal 1..40; wlast on beats 16, 32, 40; cfg_ready high after the last beat.
- AXI_DATA_WIDTH=64, DATA_WIDTH=32, length 5, words A0..A4 → one AW with awlen=2; wdata {A1,A0}, {A3,A2}, {0,A4}; wlast on the 3rd beat.
- awready held low 5 cycles, wready toggling 1/0, length 32 → awaddr/awlen/wdata stable while stalled; every word delivered exactly once; 2 bursts.
- BUF_AWIDTH=4, wready=0, length 40 → ready low after 16 FIFO entries (plus packer occupancy); wready=1 resumes; all 40 words delivered in order.
- length 0 → no awvalid/wvalid, cfg_ready high the next cycle; cfg_valid pulsed mid-transfer → ignored, no extra AW.
- rst low mid-second-burst → all valid outputs 0 immediately, cfg_ready=1; new descriptor (addr 0x2000, length 16) → one AW (0x2000,15); 16 clean beats with no stale data.
